// File: rtl/posit8_pkg.sv
// Shared posit<8,0> types, constants and decode/encode helpers used by the adder.
package posit8_pkg;
  localparam int POSIT8_W = 8;
  typedef logic [POSIT8_W-1:0] posit8_t;

  localparam posit8_t POSIT8_NAR  = 8'h80;
  localparam posit8_t POSIT8_ZERO = 8'h00;
  localparam posit8_t POSIT8_ONE  = 8'h40;

  // Decoded operand: value = (-1)^sgn * 2^sc * sig/32, sig carries the hidden one.
  typedef struct packed {
    logic              nar;
    logic              zero;
    logic              sgn;
    logic signed [4:0] sc;
    logic [5:0]        sig;
  } posit8_dec_t;

  function automatic posit8_dec_t posit8_decode(input posit8_t x);
    posit8_dec_t d;
    logic [6:0]  v;
    logic [2:0]  m;
    logic        done;
    d      = '0;
    d.nar  = (x == POSIT8_NAR);
    d.zero = (x == POSIT8_ZERO);
    d.sgn  = x[7];
    v      = 7'(x[7] ? -x : x);
    m      = 3'd1;
    done   = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (!done && v[i] == v[6]) m = m + 3'd1;
      else done = 1'b1;
    end
    d.sc  = v[6] ? $signed({2'b00, m}) - 5'sd1 : -$signed({2'b00, m});
    // Fraction follows the regime run and its terminator.
    d.sig = {1'b1, 5'(v[4:0] << (m - 3'd1))};
    return d;
  endfunction

  // Round-to-nearest-even encode; out-of-range scales saturate to maxpos/minpos.
  function automatic posit8_t posit8_encode(input logic sgn, input logic signed [6:0] sc,
                                            input logic [12:0] frac, input logic st);
    logic [19:0] w;
    logic [3:0]  len;
    logic [6:0]  pos;
    logic        g, s;
    w = '0; len = '0; pos = '0; g = 1'b0; s = 1'b0;
    if (sc >= 7'sd6) pos = 7'h7F;
    else if (sc < -7'sd6) pos = 7'h01;
    else begin
      if (sc >= 7'sd0) begin
        len = 4'(sc) + 4'd2;
        w   = ~(20'hFFFFF >> (len - 4'd1));
      end else begin
        len = 4'(-sc) + 4'd1;
        w   = 20'h80000 >> (len - 4'd1);
      end
      w   = w | ({frac, 7'b0} >> len);
      pos = w[19:13];
      g   = w[12];
      s   = (|w[11:0]) | st;
      if (g && (s || pos[0])) pos = pos + 7'd1;
    end
    return sgn ? 8'(-{1'b0, pos}) : {1'b0, pos};
  endfunction
endpackage

// File: rtl/posit_adder_8bit.sv
// Combinational posit<8,0> adder: align, add/subtract magnitudes, normalize, round.
module posit_adder_8bit
  import posit8_pkg::*;
(
  input  posit8_t i_a,
  input  posit8_t i_b,
  output posit8_t o_sum
);
  posit8_dec_t       w_a, w_b;
  logic              w_swap, w_big_sgn, w_sml_sgn;
  logic signed [4:0] w_big_sc, w_sml_sc;
  logic [5:0]        w_big_sig, w_sml_sig;
  logic [4:0]        w_dsh;
  logic [27:0]       w_shb;
  logic [14:0]       w_ma, w_mb, w_n;
  logic [15:0]       w_sum;
  logic [3:0]        w_p;
  logic signed [6:0] w_rs;

  always_comb begin
    w_a       = posit8_decode(i_a);
    w_b       = posit8_decode(i_b);
    w_swap    = ($signed(w_b.sc) > $signed(w_a.sc)) || (w_b.sc == w_a.sc && w_b.sig > w_a.sig);
    w_big_sgn = w_swap ? w_b.sgn : w_a.sgn;
    w_big_sc  = w_swap ? w_b.sc  : w_a.sc;
    w_big_sig = w_swap ? w_b.sig : w_a.sig;
    w_sml_sgn = w_swap ? w_a.sgn : w_b.sgn;
    w_sml_sc  = w_swap ? w_a.sc  : w_b.sc;
    w_sml_sig = w_swap ? w_a.sig : w_b.sig;
    w_dsh     = $unsigned(w_big_sc - w_sml_sc);
    w_shb     = {w_sml_sig, 22'b0} >> w_dsh;
    // Eight guard bits plus a sticky LSB keep rounding exact for a 5-bit fraction.
    w_ma      = {w_big_sig, 9'b0};
    w_mb      = {w_shb[27:14], |w_shb[13:0]};
    w_sum     = (w_big_sgn == w_sml_sgn) ? {1'b0, w_ma} + {1'b0, w_mb}
                                         : {1'b0, w_ma} - {1'b0, w_mb};
    w_p = '0;
    for (int i = 0; i < 16; i++) if (w_sum[i]) w_p = 4'(i);
    w_rs = $signed({{2{w_big_sc[4]}}, w_big_sc}) + $signed({3'b000, w_p}) - 7'sd14;
    w_n  = 15'(w_sum << (4'd15 - w_p));

    o_sum = posit8_encode(w_big_sgn, w_rs, w_n[14:2], |w_n[1:0]);
    if (w_a.nar || w_b.nar) o_sum = POSIT8_NAR;
    else if (w_a.zero)      o_sum = i_b;
    else if (w_b.zero)      o_sum = i_a;
    else if (w_sum == '0)   o_sum = POSIT8_ZERO;
  end
endmodule

// File: rtl/posit_rr_arbiter.sv
// Stateless round-robin picker: first requester at or above i_ptr, wrapping modulo NREQ.
module posit_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt_oh,
  output logic [ID_W-1:0] o_gnt_idx,
  output logic            o_any
);
  int w_idx;

  always_comb begin
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!o_any && i_req[w_idx]) begin
        o_any            = 1'b1;
        o_gnt_oh[w_idx]  = 1'b1;
        o_gnt_idx        = ID_W'(w_idx);
      end
    end
  end
endmodule

// File: rtl/posit_adder_arbiter_8bit.sv
// Round-robin shared posit adder: operand register, then registered sum tagged with requester id.
// Optional POSIT_ARB_STATS_EN adds saturating per-requester accept counters on grant_count.
module posit_adder_arbiter_8bit
  import posit8_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ-1:0][POSIT8_W-1:0] req_lhs,
  input  logic [NREQ-1:0][POSIT8_W-1:0] req_rhs,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [POSIT8_W-1:0]           rsp_result,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          busy
`ifdef POSIT_ARB_STATS_EN
  , output logic [NREQ-1:0][15:0]       grant_count
`endif
);
  logic            r_op_valid, r_rsp_valid;
  posit8_t         r_op_lhs, r_op_rhs, r_rsp_result;
  logic [ID_W-1:0] r_op_id, r_rsp_id, r_ptr;
  logic [NREQ-1:0] w_gnt_oh;
  logic [ID_W-1:0] w_gnt_idx, w_ptr_nxt;
  logic            w_any, w_s1_adv, w_s0_can, w_accept;
  posit8_t         w_sum;

  posit_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .o_gnt_oh  (w_gnt_oh),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  posit_adder_8bit u_add (
    .i_a   (r_op_lhs),
    .i_b   (r_op_rhs),
    .o_sum (w_sum)
  );

  assign w_s1_adv  = r_op_valid & (~r_rsp_valid | rsp_ready);
  assign w_s0_can  = ~r_op_valid | w_s1_adv;
  // Gate with rst so nothing looks accepted while the pipeline is being cleared.
  assign req_ready = w_gnt_oh & {NREQ{w_s0_can & ~rst}};
  assign w_accept  = w_any & w_s0_can & ~rst;
  assign w_ptr_nxt = (w_gnt_idx == ID_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_valid <= 1'b0;
      r_op_lhs   <= '0;
      r_op_rhs   <= '0;
      r_op_id    <= '0;
      r_ptr      <= '0;
    end else if (w_accept) begin
      r_op_valid <= 1'b1;
      r_op_lhs   <= req_lhs[w_gnt_idx];
      r_op_rhs   <= req_rhs[w_gnt_idx];
      r_op_id    <= w_gnt_idx;
      r_ptr      <= w_ptr_nxt;
    end else if (w_s1_adv) begin
      r_op_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= POSIT8_ZERO;
      r_rsp_id     <= '0;
    end else if (w_s1_adv) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= w_sum;
      r_rsp_id     <= r_op_id;
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_id     = r_rsp_id;
  assign busy       = r_op_valid | r_rsp_valid;

`ifdef POSIT_ARB_STATS_EN
  logic [NREQ-1:0][15:0] r_gcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_gcnt <= '0;
    else
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i] && req_valid[i] && r_gcnt[i] != 16'hFFFF) r_gcnt[i] <= r_gcnt[i] + 16'd1;
  end

  assign grant_count = r_gcnt;
`endif
endmodule

// File: tb/tb_posit_adder_arbiter_8bit.sv
// Directed bench for the shared posit adder arbiter; expected sums are hand-computed posit<8,0> values.
module tb_posit_adder_arbiter_8bit;
  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid, req_ready;
  logic [3:0][7:0] req_lhs, req_rhs;
  logic            rsp_valid, rsp_ready, busy;
  logic [7:0]      rsp_result;
  logic [1:0]      rsp_id;
`ifdef POSIT_ARB_STATS_EN
  logic [3:0][15:0] grant_count;
`endif

  int errs = 0;
  int checks = 0;

  // Per-requester operands: 1+1=2, 1+(-1)=0, 0.5+0.5=1, 2+1=3
  logic [7:0] lhs_tab [0:3] = '{8'h40, 8'h40, 8'h20, 8'h60};
  logic [7:0] rhs_tab [0:3] = '{8'h40, 8'hC0, 8'h20, 8'h40};
  logic [7:0] exp_tab [0:3] = '{8'h60, 8'h00, 8'h40, 8'h68};

  posit_adder_arbiter_8bit #(.NREQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_lhs    (req_lhs),
    .req_rhs    (req_rhs),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .busy       (busy)
`ifdef POSIT_ARB_STATS_EN
    , .grant_count (grant_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin req_lhs[i] = lhs_tab[i]; req_rhs[i] = rhs_tab[i]; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errs++; $display("FAIL reset_valid_busy got=%b want=00", {rsp_valid, busy}); end
    checks++; if (rsp_result !== 8'h00) begin errs++; $display("FAIL reset_result got=%h want=00", rsp_result); end
    checks++; if (rsp_id !== 2'd0) begin errs++; $display("FAIL reset_id got=%0d want=0", rsp_id); end
    checks++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1; req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    checks++; if ({rsp_valid, busy} !== 2'b01) begin errs++; $display("FAIL single_stage0 got=%b want=01", {rsp_valid, busy}); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd0, 8'h60})
      begin errs++; $display("FAIL single_rsp got=%b/%0d/%h want=1/0/60", rsp_valid, rsp_id, rsp_result); end
    @(negedge clk);
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errs++; $display("FAIL single_drain got=%b want=00", {rsp_valid, busy}); end
  endtask

  task automatic test_fairness();
    int e;
    do_reset();
    rsp_ready = 1'b1; req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'(1 << (c % 4)))
        begin errs++; $display("FAIL fair_grant c=%0d got=%b want=%b", c, req_ready, 4'(1 << (c % 4))); end
      if (c >= 2) begin
        e = (c - 2) % 4;
        checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'(e), exp_tab[e]})
          begin errs++; $display("FAIL fair_rsp c=%0d got=%b/%0d/%h want=1/%0d/%h", c, rsp_valid, rsp_id, rsp_result, e, exp_tab[e]); end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [3:0] w;
    int acc, got;
    do_reset();
    acc = 0; got = 0;
    req_valid = 4'b0111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      w = req_valid & req_ready;
      for (int i = 0; i < 4; i++) if (w[i]) acc++;
      if (c == 4) begin
        checks++; if (acc !== 2) begin errs++; $display("FAIL bp_accepts got=%0d want=2", acc); end
        checks++; if ({req_ready, busy} !== 5'b00001) begin errs++; $display("FAIL bp_stall got=%b want=00001", {req_ready, busy}); end
        checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd0, 8'h60})
          begin errs++; $display("FAIL bp_hold got=%b/%0d/%h want=1/0/60", rsp_valid, rsp_id, rsp_result); end
      end
      @(posedge clk); #1 req_valid &= ~w;
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      w = req_valid & req_ready;
      if (rsp_valid) begin
        checks++;
        if (got > 2) begin errs++; $display("FAIL bp_extra_rsp got=%0d want<=2", got); end
        else if ({rsp_id, rsp_result} !== {2'(got), exp_tab[got]})
          begin errs++; $display("FAIL bp_order got=%0d/%h want=%0d/%h", rsp_id, rsp_result, got, exp_tab[got]); end
        got++;
      end
      @(posedge clk); #1 req_valid &= ~w;
    end
    checks++; if (got !== 3) begin errs++; $display("FAIL bp_count got=%0d want=3", got); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL bp_idle got=%b want=0", busy); end
  endtask

  task automatic test_special();
    logic [7:0] sl [0:4] = '{8'h80, 8'h40, 8'h7F, 8'hC0, 8'h01};
    logic [7:0] sr [0:4] = '{8'h40, 8'hC0, 8'h7F, 8'h20, 8'h01};
    logic [7:0] se [0:4] = '{8'h80, 8'h00, 8'h7F, 8'hE0, 8'h02};
    logic ok;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req_lhs[1] = sl[k]; req_rhs[1] = sr[k]; req_valid = 4'b0010;
      ok = 1'b0;
      for (int n = 0; n < 5 && !ok; n++) begin @(negedge clk); ok = req_ready[1]; end
      checks++; if (ok !== 1'b1) begin errs++; $display("FAIL special_accept k=%0d got=%b want=1", k, ok); end
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk); @(negedge clk);
      checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd1, se[k]})
        begin errs++; $display("FAIL special k=%0d got=%b/%0d/%h want=1/1/%h", k, rsp_valid, rsp_id, rsp_result, se[k]); end
    end
  endtask

  task automatic test_reset_midflight();
    logic [3:0] w;
    do_reset();
    req_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      w = req_valid & req_ready;
      @(posedge clk); #1 req_valid &= ~w;
    end
    @(negedge clk);
    checks++; if ({rsp_valid, busy} !== 2'b11) begin errs++; $display("FAIL mid_inflight got=%b want=11", {rsp_valid, busy}); end
    #1 rst = 1'b1; req_valid = 4'b1001;
    #1;
    checks++; if ({rsp_valid, busy, req_ready} !== 6'b000000)
      begin errs++; $display("FAIL mid_reset got=%b want=000000", {rsp_valid, busy, req_ready}); end
    @(posedge clk); #1 rst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 5'b00001) begin errs++; $display("FAIL mid_ptr0 got=%b want=00001", {rsp_valid, req_ready}); end
    @(posedge clk); #1 req_valid = 4'b1000;
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin errs++; $display("FAIL mid_next got=%b want=1000", req_ready); end
    @(posedge clk); #1 req_valid = '0;
  endtask

`ifdef POSIT_ARB_STATS_EN
  task automatic test_stats();
    logic ok;
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        force dut.r_gcnt = 64'h0000_FFFF_0000_0000;
        #1 release dut.r_gcnt;
      end
      req_valid = 4'b0100; ok = 1'b0;
      for (int n = 0; n < 5 && !ok; n++) begin @(negedge clk); ok = req_ready[2]; end
      checks++; if (ok !== 1'b1) begin errs++; $display("FAIL stats_accept k=%0d got=%b want=1", k, ok); end
      @(posedge clk); #1 req_valid = '0;
      if (k == 4) begin
        checks++; if (grant_count !== {16'd0, 16'd5, 16'd0, 16'd0})
          begin errs++; $display("FAIL stats_count got=%h want=0000000500000000", grant_count); end
      end
    end
    checks++; if (grant_count[2] !== 16'hFFFF) begin errs++; $display("FAIL stats_sat got=%h want=ffff", grant_count[2]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_special();
    test_reset_midflight();
`ifdef POSIT_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/posit_adder_arbiter_8bit.md
Name: posit_adder_arbiter_8bit

Overview:
- Shares one posit_adder_8bit instance between NREQ independent requesters.
- Uses round-robin arbitration with valid/ready handshakes on both sides.
- Has a two-stage registered pipeline: operand capture, then a registered adder result.
- Each response is tagged with the requester index so downstream logic can route it. The block sits between scalar posit producers (dot-product lanes, accumulators) and a single area-expensive adder.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, response tag width; must equal clog2(NREQ).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  per-requester operand pair valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_lhs  input  NREQ*8  packed lhs posits; requester i uses bits [8i+7:8i].
- req_rhs  input  NREQ*8  packed rhs posits; same packing as req_lhs.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_result  output  8  posit sum.
- rsp_id  output  ID_W  index of the requester that issued the operation.
- busy  output  1  high when either pipeline stage holds a valid entry.

Behaviour:
- Reset (asynchronous assert, synchronous-edge release):
  - op_valid=0 and rsp_valid=0.
  - rsp_result=8'h00 and rsp_id=0.
  - Round-robin pointer=0.
  - req_ready=0 and busy=0.
- Handshakes:
  - A transfer occurs on a clock edge where valid and ready are both high.
  - Requesters must hold req_valid and their operands stable until they are accepted.
  - req_ready may depend combinationally on req_valid.
- Stage 1 (result register):
  - s1_adv = op_valid & (~rsp_valid | rsp_ready).
  - On s1_adv: rsp_result <= posit_adder_8bit(op_lhs, op_rhs), rsp_id <= op_id, rsp_valid <= 1.
  - Otherwise, if rsp_ready is high, rsp_valid <= 0.
  - The adder is purely combinational, driven only from the op_* registers.
- Stage 0 (operand register):
  - s0_can = ~op_valid | s1_adv.
  - Grant = first requester with req_valid high, searching upward from pointer and wrapping modulo NREQ.
  - req_ready = onehot(grant) & {NREQ{s0_can}}.
  - On acceptance: op_lhs/op_rhs/op_id are captured, op_valid <= 1, pointer <= (grant+1) mod NREQ.
  - If s0_can is high and nothing is accepted: op_valid <= s1_adv ? 0 : op_valid.
- Pointer: changes only on an accepted transfer. An idle requester never blocks others.
- Latency and throughput:
  - An operation accepted at edge N has rsp_valid high after edge N+1, i.e. it is visible in the cycle after N+1.
  - Throughput is 1 op/cycle with rsp_ready held high.
- Backpressure:
  - With rsp_ready low, at most two operations are in flight.
  - req_ready then stays 0 until rsp_ready rises.
  - Stalled entries hold their values.
- Simultaneous events: accepting a new op while stage 1 drains in the same edge is legal and keeps full throughput.
- Special values are passed through adder semantics:
  - NaR (8'h80) plus anything gives 8'h80.
  - x + (-x) gives 8'h00.
- Reset mid-operation discards all in-flight ops; no response is produced for them.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,NREQ-1,0.

Optional Feature:
- Macro: POSIT_ARB_STATS_EN.
- When defined, an extra output grant_count [NREQ*16] is added.
  - It holds per-requester 16-bit counters of accepted operations.
  - Each counter saturates at 16'hFFFF.
  - Counters are cleared by rst.
  - They increment on that requester's accept edge.
- When undefined, the port and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package posit8_pkg:
  - POSIT8_W=8.
  - POSIT8_NAR=8'h80.
  - POSIT8_ZERO=8'h00.
  - POSIT8_ONE=8'h40.
  - Typedef posit8_t.
- One sub-module, posit_rr_arbiter. It is combinational and holds no state (no clock or reset); the parent owns the pointer register.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any_grant.

Test Plan:
- Single op: req0 sends lhs=8'h40, rhs=8'h40 with rsp_ready=1 → accepted edge N; rsp_valid=1 with rsp_result=8'h60, rsp_id=0 at N+2.
- Fairness: all 4 requesters valid continuously with distinct operands → accept order 0,1,2,3,0,1; one rsp per cycle; ids match the order.
- Backpressure: rsp_ready=0 while 3 requesters are valid → exactly 2 accepts, then req_ready=0 and busy=1. Releasing rsp_ready drains results in order with no loss or duplication.
- Special values:
  - lhs=8'h80, rhs=8'h40 → rsp_result=8'h80.
  - lhs=8'h40, rhs=8'hC0 → rsp_result=8'h00.
- Reset mid-flight: assert rst while 2 ops are in flight → rsp_valid=0 immediately and busy=0. After release, the pointer is 0: req3 and req0 both valid → req0 is granted first.
- Stats (POSIT_ARB_STATS_EN): 5 accepts from req2 → grant_count[47:32]=16'd5, other counters 0; force a counter to 16'hFFFF → it stays at 16'hFFFF.
